// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline register/enable inputs and stall/flush/forward outputs.
// master = pipeline side driving hazard info, slave = the hazard controller.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       rs_ID;
    logic [4:0]       rt_ID;
    logic             rs_used_ID;
    logic             rt_used_ID;
    logic [4:0]       rs_EX;
    logic [4:0]       rt_EX;
    logic [4:0]       wR_EX;
    logic [4:0]       wR_MEM;
    logic [4:0]       wR_WB;
    logic             RF_we_EX;
    logic             RF_we_MEM;
    logic             RF_we_WB;
    logic             mem_read_EX;
    logic             branch_taken_EX;
    logic             dmem_req_MEM;
    logic             dmem_ack;
    logic             stall_IF;
    logic             stall_ID;
    logic             stall_EX;
    logic             stall_MEM;
    logic             flush_ID;
    logic             flush_EX;
    logic             flush_WB;
    logic [1:0]       fwdA_EX;
    logic [1:0]       fwdB_EX;
    logic [CNT_W-1:0] stall_cycles;
    logic             mem_timeout_err;

    modport master (
        output rs_ID, rt_ID, rs_used_ID, rt_used_ID, rs_EX, rt_EX,
               wR_EX, wR_MEM, wR_WB, RF_we_EX, RF_we_MEM, RF_we_WB,
               mem_read_EX, branch_taken_EX, dmem_req_MEM, dmem_ack,
        input  stall_IF, stall_ID, stall_EX, stall_MEM,
               flush_ID, flush_EX, flush_WB, fwdA_EX, fwdB_EX,
               stall_cycles, mem_timeout_err
    );

    modport slave (
        input  rs_ID, rt_ID, rs_used_ID, rt_used_ID, rs_EX, rt_EX,
               wR_EX, wR_MEM, wR_WB, RF_we_EX, RF_we_MEM, RF_we_WB,
               mem_read_EX, branch_taken_EX, dmem_req_MEM, dmem_ack,
        output stall_IF, stall_ID, stall_EX, stall_MEM,
               flush_ID, flush_EX, flush_WB, fwdA_EX, fwdB_EX,
               stall_cycles, mem_timeout_err
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: RAW/load-use stalls, branch flush,
// data-memory freeze with timeout detection, stall-cycle counter.
// Optional macro FORWARDING_EN: with it, only load-use stalls and EX operands are
// forwarded from MEM/WB; without it, any RAW on EX/MEM/WB stalls and forwarding is off.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input logic              clk,
    input logic              rst_n,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic {RUN, MEM_WAIT} state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_nxt;
    logic [CNT_W-1:0] stall_cnt;
    logic             timeout_err;
    logic             frozen;
    logic             hazard;
    logic [1:0]       fwd_a, fwd_b;

`ifdef FORWARDING_EN
    // Load-use detection against the EX-stage load, operand forwarding select (MEM beats WB)
    always_comb begin
        hazard = bus.mem_read_EX && bus.RF_we_EX && (bus.wR_EX != 5'd0) &&
                 ((bus.rs_used_ID && (bus.rs_ID == bus.wR_EX)) ||
                  (bus.rt_used_ID && (bus.rt_ID == bus.wR_EX)));
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (bus.rs_EX != 5'd0) begin
            if (bus.RF_we_MEM && (bus.wR_MEM == bus.rs_EX))     fwd_a = 2'b01;
            else if (bus.RF_we_WB && (bus.wR_WB == bus.rs_EX))  fwd_a = 2'b10;
        end
        if (bus.rt_EX != 5'd0) begin
            if (bus.RF_we_MEM && (bus.wR_MEM == bus.rt_EX))     fwd_b = 2'b01;
            else if (bus.RF_we_WB && (bus.wR_WB == bus.rt_EX))  fwd_b = 2'b10;
        end
    end
`else
    logic rs_hit, rt_hit;
    logic unused_fwd_inputs;

    assign unused_fwd_inputs = ^{bus.rs_EX, bus.rt_EX, bus.mem_read_EX};

    // Any in-flight writer of an ID source register stalls until it has retired
    always_comb begin
        rs_hit = (bus.rs_ID != 5'd0) &&
                 ((bus.RF_we_EX  && (bus.rs_ID == bus.wR_EX))  ||
                  (bus.RF_we_MEM && (bus.rs_ID == bus.wR_MEM)) ||
                  (bus.RF_we_WB  && (bus.rs_ID == bus.wR_WB)));
        rt_hit = (bus.rt_ID != 5'd0) &&
                 ((bus.RF_we_EX  && (bus.rt_ID == bus.wR_EX))  ||
                  (bus.RF_we_MEM && (bus.rt_ID == bus.wR_MEM)) ||
                  (bus.RF_we_WB  && (bus.rt_ID == bus.wR_WB)));
        hazard = (bus.rs_used_ID && rs_hit) || (bus.rt_used_ID && rt_hit);
        fwd_a  = 2'b00;
        fwd_b  = 2'b00;
    end
`endif

    // FSM next state and wait counter; freeze asserts in the cycle the wait begins
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        frozen    = 1'b0;
        case (state)
            RUN: begin
                if (bus.dmem_req_MEM && !bus.dmem_ack) begin
                    state_nxt = MEM_WAIT;
                    wait_nxt  = '0;
                    frozen    = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (bus.dmem_ack) begin
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end else begin
                    frozen = 1'b1;
                    if (wait_cnt != TIMEOUT_CNT) wait_nxt = wait_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = RUN;
                wait_nxt  = '0;
            end
        endcase
    end

    // Stall/flush/forward priority: freeze > branch > hazard; all zero in reset
    always_comb begin
        bus.stall_IF  = 1'b0;
        bus.stall_ID  = 1'b0;
        bus.stall_EX  = 1'b0;
        bus.stall_MEM = 1'b0;
        bus.flush_ID  = 1'b0;
        bus.flush_EX  = 1'b0;
        bus.flush_WB  = 1'b0;
        bus.fwdA_EX   = 2'b00;
        bus.fwdB_EX   = 2'b00;
        if (rst_n) begin
            bus.fwdA_EX = fwd_a;
            bus.fwdB_EX = fwd_b;
            if (frozen) begin
                bus.stall_IF  = 1'b1;
                bus.stall_ID  = 1'b1;
                bus.stall_EX  = 1'b1;
                bus.stall_MEM = 1'b1;
                bus.flush_WB  = 1'b1;
            end else if (bus.branch_taken_EX) begin
                bus.flush_ID = 1'b1;
                bus.flush_EX = 1'b1;
            end else if (hazard) begin
                bus.stall_IF = 1'b1;
                bus.stall_ID = 1'b1;
                bus.flush_EX = 1'b1;
            end
        end
    end

    // Registered state: FSM, wait counter, saturating stall counter, sticky timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            wait_cnt    <= '0;
            stall_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (bus.stall_IF && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if ((state == MEM_WAIT) && frozen && (wait_nxt == TIMEOUT_CNT)) timeout_err <= 1'b1;
        end
    end

    // Counter/flag outputs
    always_comb begin
        bus.stall_cycles    = stall_cnt;
        bus.mem_timeout_err = timeout_err;
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: table vectors, directed multi-cycle sequences and
// random stimulus checked against a behavioural model. Works with or without FORWARDING_EN.
module tb_pipe_hazard_ctrl;
    localparam int CNT_W = 4;
    localparam int TO    = 4;

    typedef struct packed {
        logic [4:0] rs_id;  logic rs_used;
        logic [4:0] rt_id;  logic rt_used;
        logic [4:0] rs_ex;  logic [4:0] rt_ex;
        logic [4:0] wr_ex;  logic we_ex; logic mem_read;
        logic [4:0] wr_mem; logic we_mem;
        logic [4:0] wr_wb;  logic we_wb;
        logic br; logic req; logic ack;
    } in_t;

    typedef struct packed {
        logic [3:0] stall;   // IF, ID, EX, MEM
        logic [2:0] flush;   // ID, EX, WB
        logic [1:0] fa;
        logic [1:0] fb;
    } out_t;

    typedef struct {
        in_t   v;
        out_t  exp_fwd;
        out_t  exp_nofwd;
        string name;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    // behavioural model state
    bit m_wait;
    int m_waits;
    bit m_err;
    int m_cnt;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic in_t mk(input int rs_id, rs_used, rt_id, rt_used, rs_ex, rt_ex,
                               wr_ex, we_ex, mem_read, wr_mem, we_mem, wr_wb, we_wb, br);
        in_t v;
        v = '{rs_id: 5'(rs_id), rs_used: 1'(rs_used), rt_id: 5'(rt_id), rt_used: 1'(rt_used),
              rs_ex: 5'(rs_ex), rt_ex: 5'(rt_ex), wr_ex: 5'(wr_ex), we_ex: 1'(we_ex),
              mem_read: 1'(mem_read), wr_mem: 5'(wr_mem), we_mem: 1'(we_mem),
              wr_wb: 5'(wr_wb), we_wb: 1'(we_wb), br: 1'(br), req: 1'b0, ack: 1'b0};
        return v;
    endfunction

    task automatic drive(input in_t v);
        bus.rs_ID = v.rs_id;   bus.rs_used_ID = v.rs_used;
        bus.rt_ID = v.rt_id;   bus.rt_used_ID = v.rt_used;
        bus.rs_EX = v.rs_ex;   bus.rt_EX = v.rt_ex;
        bus.wR_EX = v.wr_ex;   bus.RF_we_EX = v.we_ex;  bus.mem_read_EX = v.mem_read;
        bus.wR_MEM = v.wr_mem; bus.RF_we_MEM = v.we_mem;
        bus.wR_WB = v.wr_wb;   bus.RF_we_WB = v.we_wb;
        bus.branch_taken_EX = v.br;
        bus.dmem_req_MEM = v.req;
        bus.dmem_ack = v.ack;
    endtask

    function automatic out_t actual();
        out_t a;
        a.stall = {bus.stall_IF, bus.stall_ID, bus.stall_EX, bus.stall_MEM};
        a.flush = {bus.flush_ID, bus.flush_EX, bus.flush_WB};
        a.fa    = bus.fwdA_EX;
        a.fb    = bus.fwdB_EX;
        return a;
    endfunction

    function automatic logic [1:0] fwd_of(input in_t v, input logic [4:0] r);
        if (r == 5'd0) return 2'b00;
        if (v.we_mem && v.wr_mem == r) return 2'b01;
        if (v.we_wb && v.wr_wb == r) return 2'b10;
        return 2'b00;
    endfunction

    // Expected stall/flush/forward from the pipeline rules
    function automatic out_t model_comb(input in_t v);
        out_t       o;
        bit         frozen;
        bit         hz;
        logic [4:0] src [2];
        bit         used[2];
        logic [4:0] dst [3];
        bit         wen [3];
        o = '0;
        if (!rst_n) return o;
        src  = '{v.rs_id, v.rt_id};
        used = '{v.rs_used, v.rt_used};
        dst  = '{v.wr_ex, v.wr_mem, v.wr_wb};
        wen  = '{v.we_ex, v.we_mem, v.we_wb};
        hz = 0;
`ifdef FORWARDING_EN
        for (int i = 0; i < 2; i++)
            if (used[i] && src[i] != 0 && v.mem_read && wen[0] && src[i] == dst[0]) hz = 1;
        o.fa = fwd_of(v, v.rs_ex);
        o.fb = fwd_of(v, v.rt_ex);
`else
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 3; j++)
                if (used[i] && src[i] != 0 && wen[j] && src[i] == dst[j]) hz = 1;
`endif
        frozen = !v.ack && (m_wait || v.req);
        if (frozen) begin
            o.stall = 4'b1111; o.flush = 3'b001;
        end else if (v.br) begin
            o.flush = 3'b110;
        end else if (hz) begin
            o.stall = 4'b1100; o.flush = 3'b010;
        end
        return o;
    endfunction

    task automatic model_reset();
        m_wait = 0; m_waits = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic model_clock(input in_t v, input out_t e);
        bit frozen;
        frozen = !v.ack && (m_wait || v.req);
        if (e.stall[3] && m_cnt < (2**CNT_W - 1)) m_cnt++;
        if (frozen) begin
            if (m_wait) begin
                if (m_waits < TO) m_waits++;
                if (m_waits == TO) m_err = 1;
            end else begin
                m_wait = 1; m_waits = 0;
            end
        end else begin
            m_wait = 0; m_waits = 0;
        end
    endtask

    // One cycle: drive at negedge, check outputs mid-cycle, clock, check registers
    task automatic step(input in_t v, input string tag, output out_t a);
        out_t e;
        drive(v);
        #1;
        e = model_comb(v);
        a = actual();
        chk($sformatf("%s.stall", tag), 32'(a.stall), 32'(e.stall));
        chk($sformatf("%s.flush", tag), 32'(a.flush), 32'(e.flush));
        chk($sformatf("%s.fwd", tag), 32'({a.fa, a.fb}), 32'({e.fa, e.fb}));
        @(posedge clk);
        model_clock(v, e);
        #1;
        chk($sformatf("%s.stall_cycles", tag), 32'(bus.stall_cycles), 32'(m_cnt));
        chk($sformatf("%s.timeout_err", tag), 32'(bus.mem_timeout_err), 32'(m_err));
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk($sformatf("%s.outs", tag), 32'(actual()), 32'h0);
        chk($sformatf("%s.stall_cycles", tag), 32'(bus.stall_cycles), 32'h0);
        chk($sformatf("%s.timeout_err", tag), 32'(bus.mem_timeout_err), 32'h0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all_zero(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t tbl[$];

    initial begin
        out_t a;
        in_t  v;
        rst_n = 1'b0;
        drive('0);
        model_reset();
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        //                 rs id/used rt id/used rsEX rtEX wrEX we mr wrMEM we wrWB we br
        tbl.push_back('{mk(1,1, 2,1, 0,0, 3,1,0, 0,0, 0,0, 0), '0, '0, "no_dep"});
        tbl.push_back('{mk(3,1, 2,1, 0,0, 3,1,0, 0,0, 0,0, 0), '0,
                        '{4'b1100, 3'b010, 2'b00, 2'b00}, "raw_ex_alu"});
        tbl.push_back('{mk(1,1, 6,1, 0,0, 6,1,1, 0,0, 0,0, 0),
                        '{4'b1100, 3'b010, 2'b00, 2'b00},
                        '{4'b1100, 3'b010, 2'b00, 2'b00}, "load_use_rt"});
        tbl.push_back('{mk(1,1, 6,0, 0,0, 6,1,1, 0,0, 0,0, 0), '0, '0, "load_rt_unused"});
        tbl.push_back('{mk(0,1, 0,1, 0,0, 0,1,1, 0,1, 0,1, 0), '0, '0, "reg0"});
        tbl.push_back('{mk(6,1, 0,0, 0,0, 6,0,1, 0,0, 0,0, 0), '0, '0, "load_no_we"});
        tbl.push_back('{mk(1,0, 5,1, 0,0, 0,0,0, 0,0, 5,1, 0), '0,
                        '{4'b1100, 3'b010, 2'b00, 2'b00}, "raw_wb"});
        tbl.push_back('{mk(7,1, 0,0, 0,0, 0,0,0, 7,1, 0,0, 0), '0,
                        '{4'b1100, 3'b010, 2'b00, 2'b00}, "raw_mem"});
        tbl.push_back('{mk(1,1, 6,1, 0,0, 6,1,1, 0,0, 0,0, 1),
                        '{4'b0000, 3'b110, 2'b00, 2'b00},
                        '{4'b0000, 3'b110, 2'b00, 2'b00}, "branch_over_hazard"});
        tbl.push_back('{mk(1,1, 2,1, 0,0, 0,0,0, 0,0, 0,0, 1),
                        '{4'b0000, 3'b110, 2'b00, 2'b00},
                        '{4'b0000, 3'b110, 2'b00, 2'b00}, "branch_only"});
        tbl.push_back('{mk(0,0, 0,0, 4,7, 0,0,0, 4,1, 4,1, 0),
                        '{4'b0000, 3'b000, 2'b01, 2'b00}, '0, "fwd_mem_priority"});
        tbl.push_back('{mk(0,0, 0,0, 4,4, 0,0,0, 4,0, 4,1, 0),
                        '{4'b0000, 3'b000, 2'b10, 2'b10}, '0, "fwd_wb"});
        tbl.push_back('{mk(0,0, 0,0, 4,5, 0,0,0, 5,1, 4,1, 0),
                        '{4'b0000, 3'b000, 2'b10, 2'b01}, '0, "fwd_split"});
        tbl.push_back('{mk(0,0, 0,0, 0,0, 0,0,0, 0,1, 0,1, 0), '0, '0, "fwd_r0"});

        foreach (tbl[i]) begin
            out_t exp_o;
`ifdef FORWARDING_EN
            exp_o = tbl[i].exp_fwd;
`else
            exp_o = tbl[i].exp_nofwd;
`endif
            step(tbl[i].v, tbl[i].name, a);
            chk($sformatf("tbl.%s", tbl[i].name), 32'(a), 32'(exp_o));
        end

        // Producer of r3 walks EX -> MEM -> WB while ID keeps reading r3
        do_reset("seq_raw.reset");
`ifdef FORWARDING_EN
        step(mk(3,1, 0,0, 0,0, 3,1,1, 0,0, 0,0, 0), "seq_raw.ex", a);
`else
        step(mk(3,1, 0,0, 0,0, 3,1,0, 0,0, 0,0, 0), "seq_raw.ex", a);
`endif
        step(mk(3,1, 0,0, 0,0, 0,0,0, 3,1, 0,0, 0), "seq_raw.mem", a);
        step(mk(3,1, 0,0, 0,0, 0,0,0, 0,0, 3,1, 0), "seq_raw.wb", a);
        step(mk(3,1, 0,0, 0,0, 0,0,0, 0,0, 0,0, 0), "seq_raw.clear", a);
        chk("seq_raw.clear_outs", 32'(a), 32'h0);
`ifdef FORWARDING_EN
        chk("seq_raw.total", 32'(bus.stall_cycles), 32'd1);
`else
        chk("seq_raw.total", 32'(bus.stall_cycles), 32'd3);
`endif

        // Memory timeout with a branch and load-use held behind the freeze
        do_reset("seq_to.reset");
        v = mk(1,1, 6,1, 0,0, 6,1,1, 0,0, 0,0, 1);
        v.req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(v, $sformatf("seq_to.wait%0d", i), a);
            chk($sformatf("seq_to.freeze%0d", i), 32'(a), 32'({4'b1111, 3'b001, 4'b0000}));
            if (i == 3) chk("seq_to.err_before", 32'(bus.mem_timeout_err), 32'd0);
            if (i == 4) chk("seq_to.err_set", 32'(bus.mem_timeout_err), 32'd1);
        end
        v.ack = 1'b1;
        step(v, "seq_to.release", a);
        chk("seq_to.release_outs", 32'(a), 32'({4'b0000, 3'b110, 4'b0000}));
        chk("seq_to.err_sticky", 32'(bus.mem_timeout_err), 32'd1);
        chk("seq_to.stall_cnt", 32'(bus.stall_cycles), 32'd6);
        step('0, "seq_to.after", a);
        chk("seq_to.after_outs", 32'(a), 32'h0);

        // Asynchronous reset in the middle of a memory wait
        do_reset("seq_rst.pre");
        v = '0;
        v.req = 1'b1;
        for (int i = 0; i < 6; i++) step(v, $sformatf("seq_rst.wait%0d", i), a);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all_zero("seq_rst.async");
        @(negedge clk);
        check_all_zero("seq_rst.held");
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(v, $sformatf("seq_rst.rewait%0d", i), a);
        chk("seq_rst.err_clear", 32'(bus.mem_timeout_err), 32'd0);
        v.ack = 1'b1;
        step(v, "seq_rst.ack", a);

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 149) == 0) do_reset("rnd.reset");
            v = mk($urandom_range(0,7), $urandom_range(0,1), $urandom_range(0,7), $urandom_range(0,1),
                   $urandom_range(0,7), $urandom_range(0,7),
                   $urandom_range(0,7), $urandom_range(0,1), $urandom_range(0,1),
                   $urandom_range(0,7), $urandom_range(0,1),
                   $urandom_range(0,7), $urandom_range(0,1),
                   ($urandom_range(0,4) == 0) ? 1 : 0);
            v.req = ($urandom_range(0,3) == 0);
            v.ack = ($urandom_range(0,2) == 0);
            step(v, $sformatf("rnd%0d", n), a);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
